// File: rtl/zrb_spi_slave.sv
// -----------------------------------------------------------------------------
// zrb_spi_slave
//  SPI target for the zrb SPI link. Mode 0 (CPOL=0, CPHA=0), MSB first.
//  The SPI pins are asynchronous to clk. They are oversampled through a 2-FF
//  synchroniser. A third register stage provides edge detection.
//  Words to send on miso come from a TX FIFO. Words received on mosi go to an
//  RX FIFO with first-word fall-through.
//
// Ports
//  clk          system clock, must be >= 4x sck frequency
//  reset_n      synchronous reset, active low
//  sck, cs_n,   SPI pins from the master (asynchronous)
//  mosi
//  miso         serial data to master
//  miso_oe      pad output enable, equals synchronised ~cs_n
//  tx_data/     push a word into the TX FIFO (ignored when tx_full)
//  tx_wr
//  tx_full      TX FIFO full
//  rx_data      head of the RX FIFO (fall-through)
//  rx_rd        pop the RX head (ignored when rx_empty)
//  rx_empty     RX FIFO empty
//  rx_overflow  sticky: a received word was dropped because RX was full
//  tx_underrun  sticky: FILL_WORD was sent because TX was empty
//  busy         synchronised cs_n is low
// -----------------------------------------------------------------------------
module zrb_spi_slave #(
    parameter int                  NUM_BITS   = 8,
    parameter int                  ADDR_WIDTH = 2,
    parameter logic [NUM_BITS-1:0] FILL_WORD  = 8'hFF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                sck,
    input  logic                cs_n,
    input  logic                mosi,
    output logic                miso,
    output logic                miso_oe,
    input  logic [NUM_BITS-1:0] tx_data,
    input  logic                tx_wr,
    output logic                tx_full,
    output logic [NUM_BITS-1:0] rx_data,
    input  logic                rx_rd,
    output logic                rx_empty,
    output logic                rx_overflow,
    output logic                tx_underrun,
    output logic                busy
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CNT_W = $clog2(NUM_BITS + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;

    // Synchroniser bit positions and their idle (reset) levels.
    localparam int         P_SCK    = 2;
    localparam int         P_CS     = 1;
    localparam int         P_MOSI   = 0;
    localparam logic [2:0] SYNC_RST = 3'b010;

    // ------------------------------------------------------------------
    // Pin synchroniser and edge detect
    // ------------------------------------------------------------------
    logic [2:0] w_pins;
    logic [2:0] r_s1;
    logic [2:0] r_s2;
    logic [2:0] r_s3;

    assign w_pins = {sck, cs_n, mosi};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_s1 <= SYNC_RST;
            r_s2 <= SYNC_RST;
            r_s3 <= SYNC_RST;
        end else begin
            r_s1 <= w_pins;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    logic w_sck_rise;
    logic w_sck_fall;
    logic w_cs_rise;
    logic w_cs_fall;
    logic w_mosi_s;

    assign w_sck_rise = r_s2[P_SCK] & ~r_s3[P_SCK];
    assign w_sck_fall = ~r_s2[P_SCK] & r_s3[P_SCK];
    assign w_cs_rise  = r_s2[P_CS] & ~r_s3[P_CS];
    assign w_cs_fall  = ~r_s2[P_CS] & r_s3[P_CS];
    // mosi goes through the same number of stages as sck. The sampled bit
    // is therefore aligned with the detected sck edge.
    assign w_mosi_s   = r_s2[P_MOSI];

    // ------------------------------------------------------------------
    // FIFOs: pointers carry one extra wrap bit
    // ------------------------------------------------------------------
    logic [NUM_BITS-1:0] r_tx_mem [DEPTH];
    logic [NUM_BITS-1:0] r_rx_mem [DEPTH];
    logic [ADDR_WIDTH:0] r_tx_wr_ptr;
    logic [ADDR_WIDTH:0] r_tx_rd_ptr;
    logic [ADDR_WIDTH:0] r_rx_wr_ptr;
    logic [ADDR_WIDTH:0] r_rx_rd_ptr;

    logic w_tx_empty;
    logic w_tx_full;
    logic w_rx_empty;
    logic w_rx_full;

    assign w_tx_empty = (r_tx_wr_ptr == r_tx_rd_ptr);
    assign w_tx_full  = (r_tx_wr_ptr[ADDR_WIDTH] != r_tx_rd_ptr[ADDR_WIDTH]) &&
                        (r_tx_wr_ptr[ADDR_WIDTH-1:0] == r_tx_rd_ptr[ADDR_WIDTH-1:0]);
    assign w_rx_empty = (r_rx_wr_ptr == r_rx_rd_ptr);
    assign w_rx_full  = (r_rx_wr_ptr[ADDR_WIDTH] != r_rx_rd_ptr[ADDR_WIDTH]) &&
                        (r_rx_wr_ptr[ADDR_WIDTH-1:0] == r_rx_rd_ptr[ADDR_WIDTH-1:0]);

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    logic [1:0]          r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_word_done;
    logic [NUM_BITS-1:0] r_shift_tx;
    logic [NUM_BITS-1:0] r_shift_rx;
    logic                r_miso;
    logic                r_rx_overflow;
    logic                r_tx_underrun;

    logic                w_load;
    logic                w_word_end;
    logic                w_tx_push;
    logic                w_tx_pop;
    logic                w_rx_push;
    logic                w_rx_pop;
    logic [NUM_BITS-1:0] w_tx_head;
    logic [NUM_BITS-1:0] w_load_word;
    logic [NUM_BITS-1:0] w_rx_word;

    // cs_n rise takes priority over every other pin event.
    // A TX word is fetched in LOAD and again on the sck fall after each
    // completed word.
    assign w_load = ~w_cs_rise &
                    ((r_state == ST_LOAD) ||
                     ((r_state == ST_SHIFT) && w_sck_fall && r_word_done));

    assign w_word_end = ~w_cs_rise && (r_state == ST_SHIFT) && w_sck_rise &&
                        (r_cnt == CNT_W'(NUM_BITS - 1));

    assign w_tx_head   = r_tx_mem[r_tx_rd_ptr[ADDR_WIDTH-1:0]];
    assign w_load_word = w_tx_empty ? FILL_WORD : w_tx_head;
    assign w_rx_word   = {r_shift_rx[NUM_BITS-2:0], w_mosi_s};

    assign w_tx_push = tx_wr & ~w_tx_full;
    assign w_tx_pop  = w_load & ~w_tx_empty;
    assign w_rx_push = w_word_end & ~w_rx_full;
    assign w_rx_pop  = rx_rd & ~w_rx_empty;

    // Storage arrays have no reset. The pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (w_tx_push) begin
            r_tx_mem[r_tx_wr_ptr[ADDR_WIDTH-1:0]] <= tx_data;
        end
        if (w_rx_push) begin
            r_rx_mem[r_rx_wr_ptr[ADDR_WIDTH-1:0]] <= w_rx_word;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_tx_wr_ptr <= '0;
            r_tx_rd_ptr <= '0;
            r_rx_wr_ptr <= '0;
            r_rx_rd_ptr <= '0;
        end else begin
            if (w_tx_push) r_tx_wr_ptr <= r_tx_wr_ptr + 1'b1;
            if (w_tx_pop)  r_tx_rd_ptr <= r_tx_rd_ptr + 1'b1;
            if (w_rx_push) r_rx_wr_ptr <= r_rx_wr_ptr + 1'b1;
            if (w_rx_pop)  r_rx_rd_ptr <= r_rx_rd_ptr + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Transfer FSM and shift registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_word_done   <= 1'b0;
            r_shift_tx    <= '0;
            r_shift_rx    <= '0;
            r_miso        <= 1'b1;
            r_rx_overflow <= 1'b0;
            r_tx_underrun <= 1'b0;
        end else begin
            if (w_load && w_tx_empty) r_tx_underrun <= 1'b1;
            if (w_word_end && w_rx_full) r_rx_overflow <= 1'b1;

            if (w_cs_rise) begin
                // Frame end: any partial RX word is abandoned.
                r_state     <= ST_IDLE;
                r_cnt       <= '0;
                r_word_done <= 1'b0;
                r_miso      <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_cs_fall) r_state <= ST_LOAD;
                    end
                    ST_LOAD: begin
                        r_shift_tx  <= w_load_word;
                        r_miso      <= w_load_word[NUM_BITS-1];
                        r_cnt       <= '0;
                        r_word_done <= 1'b0;
                        r_state     <= ST_SHIFT;
                    end
                    ST_SHIFT: begin
                        if (w_sck_rise) begin
                            r_shift_rx <= w_rx_word;
                            if (w_word_end) begin
                                r_cnt       <= '0;
                                r_word_done <= 1'b1;
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end else if (w_sck_fall) begin
                            if (r_word_done) begin
                                // First bit of the next word goes out on the
                                // fall after the last rise of the previous word.
                                r_shift_tx  <= w_load_word;
                                r_miso      <= w_load_word[NUM_BITS-1];
                                r_word_done <= 1'b0;
                            end else begin
                                r_shift_tx <= r_shift_tx << 1;
                                r_miso     <= r_shift_tx[NUM_BITS-2];
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign miso        = r_miso;
    assign miso_oe     = ~r_s2[P_CS];
    assign busy        = ~r_s2[P_CS];
    assign tx_full     = w_tx_full;
    assign rx_empty    = w_rx_empty;
    assign rx_data     = r_rx_mem[r_rx_rd_ptr[ADDR_WIDTH-1:0]];
    assign rx_overflow = r_rx_overflow;
    assign tx_underrun = r_tx_underrun;

endmodule

// File: tb/tb_zrb_spi_slave.sv
// -----------------------------------------------------------------------------
// tb_zrb_spi_slave
//  Directed and randomised bench for zrb_spi_slave.
//  A mode-0 master is modelled with tasks.
//  The reference model is queue based and kept at the transaction level:
//   - the TX queue supplies one word at frame start and one word after every
//     completed word;
//   - the RX queue accepts each completed word while fewer than 4 are held.
// -----------------------------------------------------------------------------
module tb_zrb_spi_slave;

    localparam int HALF  = 6;   // sck half period in clk cycles
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       sck = 1'b0;
    logic       cs_n = 1'b1;
    logic       mosi = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_wr = 1'b0;
    logic       rx_rd = 1'b0;
    logic       miso;
    logic       miso_oe;
    logic       tx_full;
    logic [7:0] rx_data;
    logic       rx_empty;
    logic       rx_overflow;
    logic       tx_underrun;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [7:0] tx_m[$];
    logic [7:0] rx_m[$];
    logic [7:0] exp_m[$];   // words the master should see, in order
    logic       ovf_m = 1'b0;
    logic       und_m = 1'b0;

    zrb_spi_slave #(
        .NUM_BITS   (8),
        .ADDR_WIDTH (2),
        .FILL_WORD  (8'hFF)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .sck         (sck),
        .cs_n        (cs_n),
        .mosi        (mosi),
        .miso        (miso),
        .miso_oe     (miso_oe),
        .tx_data     (tx_data),
        .tx_wr       (tx_wr),
        .tx_full     (tx_full),
        .rx_data     (rx_data),
        .rx_rd       (rx_rd),
        .rx_empty    (rx_empty),
        .rx_overflow (rx_overflow),
        .tx_underrun (tx_underrun),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic void m_fetch_tx();
        if (tx_m.size() > 0) begin
            exp_m.push_back(tx_m.pop_front());
        end else begin
            exp_m.push_back(8'hFF);
            und_m = 1'b1;
        end
    endfunction

    function automatic void m_rx_word(input logic [7:0] w);
        if (rx_m.size() < DEPTH) rx_m.push_back(w);
        else ovf_m = 1'b1;
    endfunction

    function automatic void m_reset();
        tx_m.delete();
        rx_m.delete();
        exp_m.delete();
        ovf_m = 1'b0;
        und_m = 1'b0;
    endfunction

    // ---------------- local-side tasks ----------------
    task automatic push_tx(input logic [7:0] d);
        @(negedge clk);
        tx_data = d;
        tx_wr   = 1'b1;
        @(negedge clk);
        tx_wr   = 1'b0;
        if (tx_m.size() < DEPTH) tx_m.push_back(d);
        $display("tb: tx_wr %02h (model depth %0d)", d, tx_m.size());
    endtask

    task automatic pop_rx();
        @(negedge clk);
        chk("rx_empty_before_rd", rx_empty, (rx_m.size() == 0));
        if (rx_m.size() > 0) begin
            chk("rx_data", rx_data, rx_m[0]);
            $display("tb: rx_rd got %02h exp %02h", rx_data, rx_m[0]);
        end else begin
            $display("tb: rx_rd while empty");
        end
        rx_rd = 1'b1;
        @(negedge clk);
        rx_rd = 1'b0;
        if (rx_m.size() > 0) void'(rx_m.pop_front());
        chk("rx_empty_after_rd", rx_empty, (rx_m.size() == 0));
    endtask

    task automatic check_status();
        @(negedge clk);
        chk("tx_full", tx_full, (tx_m.size() == DEPTH));
        chk("rx_empty", rx_empty, (rx_m.size() == 0));
        chk("rx_overflow", rx_overflow, ovf_m);
        chk("tx_underrun", tx_underrun, und_m);
        if (rx_m.size() > 0) chk("rx_head", rx_data, rx_m[0]);
    endtask

    // ---------------- master-side tasks ----------------
    task automatic cs_lo();
        @(negedge clk);
        cs_n = 1'b0;
        m_fetch_tx();
        repeat (HALF) @(negedge clk);
    endtask

    task automatic cs_hi();
        repeat (HALF) @(negedge clk);
        cs_n = 1'b1;
        exp_m.delete();
        repeat (HALF) @(negedge clk);
        chk("busy_idle", busy, 1'b0);
        chk("miso_oe_idle", miso_oe, 1'b0);
        chk("miso_idle", miso, 1'b1);
    endtask

    // Shift nbits (MSB first) of one word. A full 8-bit word is completed
    // in the model. A shorter transfer is a partial word.
    task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        logic [7:0] e;
        e  = (exp_m.size() > 0) ? exp_m[0] : 8'hxx;
        mi = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi = mo[7-i];
            repeat (HALF) @(negedge clk);
            mi[7-i] = miso;
            if (i == 0) begin
                chk("miso_oe", miso_oe, 1'b1);
                chk("busy", busy, 1'b1);
            end
            chk("miso_bit", miso, e[7-i]);
            sck = 1'b1;
            repeat (HALF) @(negedge clk);
            sck = 1'b0;
        end
        if (nbits == 8) begin
            chk("master_word", mi, e);
            $display("tb: spi word mosi %02h miso %02h exp %02h", mo, mi, e);
            void'(exp_m.pop_front());
            m_rx_word(mo);
            m_fetch_tx();
        end else begin
            $display("tb: spi partial %0d bits mosi %02h", nbits, mo);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            sck  = 1'($urandom_range(0, 1));
            cs_n = 1'($urandom_range(0, 1));
            mosi = 1'($urandom_range(0, 1));
        end
        sck  = 1'b0;
        cs_n = 1'b1;
        mosi = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        m_reset();
        @(negedge clk);
        chk("rst_miso", miso, 1'b1);
        chk("rst_miso_oe", miso_oe, 1'b0);
        chk("rst_busy", busy, 1'b0);
        $display("tb: reset applied");
        check_status();
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] mi;
        int         nw;
        int         np;

        // 1. reset with pins toggling
        do_reset();

        // 2. single word frame
        push_tx(8'hA5);
        cs_lo();
        xfer(8'h3C, 8, mi);
        cs_hi();
        check_status();
        pop_rx();

        // 3. two word frame, no cs gap
        push_tx(8'h11);
        push_tx(8'h22);
        cs_lo();
        xfer(8'hDE, 8, mi);
        xfer(8'hAD, 8, mi);
        cs_hi();
        check_status();
        pop_rx();
        pop_rx();

        // 4. TX empty: fill word
        cs_lo();
        xfer(8'h00, 8, mi);
        cs_hi();
        check_status();
        pop_rx();

        // 5. RX overflow
        cs_lo();
        for (int i = 1; i <= 5; i++) xfer(8'(i), 8, mi);
        cs_hi();
        check_status();
        for (int i = 0; i < 5; i++) pop_rx();   // last one is a read while empty
        check_status();

        // TX full: 5th push ignored
        for (int i = 0; i < 5; i++) push_tx(8'($urandom));
        check_status();
        cs_lo();
        for (int i = 0; i < 4; i++) xfer(8'($urandom), 8, mi);
        cs_hi();
        check_status();
        for (int i = 0; i < 4; i++) pop_rx();

        // 6. aborted partial word, then a full frame, then reset mid-word
        push_tx(8'($urandom));
        cs_lo();
        xfer(8'($urandom), 3, mi);
        cs_hi();
        check_status();
        cs_lo();
        xfer(8'h5A, 8, mi);
        cs_hi();
        check_status();
        pop_rx();
        check_status();
        push_tx(8'hC3);
        cs_lo();
        xfer(8'h99, 5, mi);
        do_reset();

        // Randomised frames
        for (int it = 0; it < 12; it++) begin
            np = $urandom_range(0, 5);
            for (int k = 0; k < np; k++) push_tx(8'($urandom));
            check_status();
            nw = $urandom_range(1, 3);
            cs_lo();
            for (int k = 0; k < nw; k++) xfer(8'($urandom), 8, mi);
            if ($urandom_range(0, 2) == 0) xfer(8'($urandom), $urandom_range(1, 7), mi);
            cs_hi();
            check_status();
            np = $urandom_range(0, rx_m.size() + 1);
            for (int k = 0; k < np; k++) pop_rx();
            if (it == 7) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
